ram_wstrb: RTL and testbench
============================

Name: ram_wstrb

Overview:
- Parametrised successor to the core's single-port word RAM. Synchronous single-port block RAM with configurable depth and data width, per-byte write strobes, and a valid/ready request handshake.
- Adds a registered-output option (LATENCY 1 or 2) and an optional hardware clear sequence after reset.
- Sits between the CPU load/store unit or instruction fetch and on-chip memory.

Parameters:
- ADDR_WIDTH, 11, word-index bits used (depth = 2**ADDR_WIDTH words).
- DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
- LATENCY, 1, read latency in cycles from accepted request to rdata_valid; legal values are 1 or 2.
- CLEAR_ON_RESET, 1, when 1 every word is zeroed after reset before requests are accepted; when 0 no clear is performed.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request this cycle.
- req_we  input  1  1 = write, 0 = read.
- addr  input  30  word address; only addr[ADDR_WIDTH-1:0] is used.
- wdata  input  DATA_WIDTH  write data.
- wstrb  input  DATA_WIDTH/8  byte enables; bit i covers wdata[8i+7:8i].
- rdata  output  DATA_WIDTH  read data.
- rdata_valid  output  1  one-cycle pulse; rdata holds the data of a completed read.

Behaviour:
- Reset values: req_ready=0, rdata=0, rdata_valid=0, any LATENCY-2 pipeline valid bits cleared. Memory contents are not reset except by the clear sequence.
- A request is accepted when req_valid && req_ready on a rising edge.
- State machine has two states, CLEAR and IDLE.
  - reset -> CLEAR if CLEAR_ON_RESET=1, otherwise -> IDLE.
  - CLEAR: clear_ptr starts at 0 and advances by 1 each cycle, writing all-zero to word clear_ptr. req_ready=0.
  - After word 2**ADDR_WIDTH-1 is written, next state is IDLE. The clear therefore takes exactly 2**ADDR_WIDTH cycles.
  - IDLE: req_ready=1 every cycle; no back-pressure.
- Reset asserted in any state, including mid-CLEAR, restarts from the reset values and restarts the clear from pointer 0.
- Write: an accepted write with req_we=1 updates each byte i where wstrb[i]=1. Other bytes keep their value. wstrb=0 is accepted and has no effect. Writes produce no response and do not assert rdata_valid.
- Read, LATENCY=1: rdata and rdata_valid are updated on the edge that accepts the request, so they are visible in the next cycle.
- Read, LATENCY=2: the array output is registered once more. rdata and rdata_valid appear one cycle after the LATENCY=1 timing.
- Throughput is one request per cycle, fully pipelined.
- rdata holds its last read value until the next read completes. It is not cleared when rdata_valid falls.
- Read during write: a single port accepts one request per cycle, so a read and a write cannot be accepted in the same cycle.
- Back-to-back write then read of the same address returns the new data. Read then write returns the old data.
- Address aliasing: addr bits above ADDR_WIDTH-1 are ignored, so address 2**ADDR_WIDTH aliases address 0.
- Reset during an outstanding read drops that read: no rdata_valid pulse is produced for it.

Test Plan:
- Clear sequence (CLEAR_ON_RESET=1, ADDR_WIDTH=4):
  - Stimulus: pulse reset, then hold req_valid=1.
  - Response: req_ready stays 0 for exactly 16 cycles after reset deasserts, then goes to 1.
  - Reading words 0..15 then returns 0x00000000 each.
- Byte strobes (LATENCY=1):
  - Stimulus: write 0xAABBCCDD to addr 5 with wstrb=1111, then write 0x11223344 with wstrb=0101, then read addr 5.
  - Response: rdata=0xAA22CC44, with rdata_valid high exactly 1 cycle after acceptance.
- Latency 2 streaming:
  - Stimulus: write words 0..7 with values 0x100+i, then issue 8 back-to-back reads of 0..7.
  - Response: 8 consecutive rdata_valid pulses starting 2 cycles after the first read is accepted, in order, with values 0x100..0x107.
- Write then read, same address:
  - Stimulus: write 0xDEADBEEF to addr 3 in cycle n, read addr 3 in cycle n+1.
  - Response: rdata=0xDEADBEEF.
- Aliasing:
  - Stimulus: ADDR_WIDTH=4, write 0x5A5A5A5A to addr 0x10, then read addr 0.
  - Response: rdata=0x5A5A5A5A.
- Reset mid-operation:
  - Stimulus: assert reset at clear_ptr=7 during CLEAR, and separately assert reset the cycle after a read is accepted with LATENCY=2.
  - Response: the clear restarts, with req_ready low for the full 2**ADDR_WIDTH cycles again. No rdata_valid pulse appears for the dropped read, and rdata=0.

Source files
------------

// File: rtl/ram_wstrb.sv
// Single-port synchronous word RAM with per-byte write strobes, valid/ready
// request handshake, 1- or 2-cycle read latency and an optional post-reset clear.
module ram_wstrb #(
    parameter int ADDR_WIDTH     = 11,
    parameter int DATA_WIDTH     = 32,
    parameter int LATENCY        = 1,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [29:0]             addr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic                    rdata_valid
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int NB    = DATA_WIDTH / 8;

    typedef enum logic {CLEAR, IDLE} state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   clear_ptr;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic [ADDR_WIDTH-1:0]   idx_p0;
    logic                    acc_p0;
    logic                    rd_p0;
    logic                    wr_p0;

    // A request seen while reset is high is never accepted.
    assign idx_p0 = addr[ADDR_WIDTH-1:0];
    assign acc_p0 = req_valid && req_ready && !reset;
    assign rd_p0  = acc_p0 && !req_we;
    assign wr_p0  = acc_p0 && req_we;

    if (ADDR_WIDTH < 30) begin : g_alias
        logic unused_addr_bits;
        assign unused_addr_bits = ^addr[29:ADDR_WIDTH];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= CLEAR_ON_RESET ? CLEAR : IDLE;
            clear_ptr <= '0;
            req_ready <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    clear_ptr <= clear_ptr + 1'b1;
                    if (&clear_ptr) begin
                        state     <= IDLE;
                        req_ready <= 1'b1;
                    end
                end
                IDLE: req_ready <= 1'b1;
            endcase
        end
    end

    // Array write port: clear sweep or strobed request write.
    always_ff @(posedge clk) begin
        if (!reset && state == CLEAR) begin
            mem[clear_ptr] <= '0;
        end else if (wr_p0) begin
            for (int i = 0; i < NB; i++) begin
                if (wstrb[i]) mem[idx_p0][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    if (LATENCY == 1) begin : g_lat1
        // Stage p0 -> output: array read lands directly in rdata.
        always_ff @(posedge clk) begin
            if (reset) begin
                rdata       <= '0;
                rdata_valid <= 1'b0;
            end else begin
                rdata_valid <= rd_p0;
                if (rd_p0) rdata <= mem[idx_p0];
            end
        end
    end else begin : g_lat2
        logic [DATA_WIDTH-1:0] data_p1;
        logic                  vld_p1;

        // Stage p0 -> p1: array output register.
        always_ff @(posedge clk) begin
            if (rd_p0) data_p1 <= mem[idx_p0];
        end

        // Stage p1 -> output: dropping vld_p1 on reset discards the read.
        always_ff @(posedge clk) begin
            if (reset) begin
                vld_p1      <= 1'b0;
                rdata       <= '0;
                rdata_valid <= 1'b0;
            end else begin
                vld_p1      <= rd_p0;
                rdata_valid <= vld_p1;
                if (vld_p1) rdata <= data_p1;
            end
        end
    end

endmodule

// File: tb/tb_ram_wstrb.sv
// Bench for ram_wstrb: a LATENCY=1 and a LATENCY=2 instance (16 words, clear on
// reset) share one stimulus stream and are checked against a word-array model.
module tb_ram_wstrb;

    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_we;
    logic [29:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;

    logic        rdy1, rdy2, rv1, rv2;
    logic [31:0] rd1, rd2;

    always #5 clk = ~clk;

    ram_wstrb #(.ADDR_WIDTH(AW), .DATA_WIDTH(32), .LATENCY(1), .CLEAR_ON_RESET(1'b1)) dut1 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rdy1),
        .req_we(req_we), .addr(addr), .wdata(wdata), .wstrb(wstrb),
        .rdata(rd1), .rdata_valid(rv1)
    );

    ram_wstrb #(.ADDR_WIDTH(AW), .DATA_WIDTH(32), .LATENCY(2), .CLEAR_ON_RESET(1'b1)) dut2 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rdy2),
        .req_we(req_we), .addr(addr), .wdata(wdata), .wstrb(wstrb),
        .rdata(rd2), .rdata_valid(rv2)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit rst_q  = 1'b0;
    bit mon_en = 1'b0;

    logic [31:0] mem_m [DEPTH];

    typedef struct {
        int          due;
        logic [31:0] d;
    } pend_t;

    pend_t       q1[$];
    pend_t       q2[$];
    logic [31:0] held1 = '0;
    logic [31:0] held2 = '0;

    typedef struct {
        bit          we;
        logic [29:0] a;
        logic [31:0] d;
        logic [3:0]  s;
        logic [31:0] exp;
    } vec_t;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= reset;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h, want %h", nm, cyc, act, exp);
        end
    endtask

    // Read responses are due at fixed cycle numbers; anything else must be quiet.
    always @(negedge clk) begin
        if (mon_en) begin
            bit e1, e2;
            if (rst_q) begin
                q1.delete();
                q2.delete();
                held1 = '0;
                held2 = '0;
            end
            e1 = (q1.size() > 0) && (q1[0].due == cyc);
            e2 = (q2.size() > 0) && (q2[0].due == cyc);
            if (e1) begin held1 = q1[0].d; q1.delete(0); end
            if (e2) begin held2 = q2[0].d; q2.delete(0); end
            chk("l1_valid", {31'd0, rv1}, {31'd0, e1});
            chk("l1_rdata", rd1, held1);
            chk("l2_valid", {31'd0, rv2}, {31'd0, e2});
            chk("l2_rdata", rd2, held2);
        end
    end

    // Called at posedge+1; returns at posedge+1 after the request is accepted.
    task automatic issue(input bit we, input logic [29:0] a, input logic [31:0] d,
                         input logic [3:0] s, input bit use_exp, input logic [31:0] e);
        int idx;
        req_valid = 1'b1;
        req_we    = we;
        addr      = a;
        wdata     = d;
        wstrb     = s;
        @(negedge clk);
        chk("ready_l1", {31'd0, rdy1}, 32'd1);
        chk("ready_l2", {31'd0, rdy2}, 32'd1);
        idx = int'(a % 30'(DEPTH));
        if (we) begin
            for (int i = 0; i < 4; i++)
                if (s[i]) mem_m[idx][8*i +: 8] = d[8*i +: 8];
        end else begin
            q1.push_back('{due: cyc + 1, d: use_exp ? e : mem_m[idx]});
            q2.push_back('{due: cyc + 2, d: use_exp ? e : mem_m[idx]});
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Pulse reset with a read held pending and count cycles with req_ready low.
    task automatic reset_and_clear(input string nm);
        int n;
        reset     = 1'b1;
        req_valid = 1'b1;
        req_we    = 1'b0;
        addr      = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        n = 0;
        while (n < 100) begin
            @(negedge clk);
            if (rdy1 && rdy2) break;
            n++;
        end
        req_valid = 1'b0;
        chk(nm, n, DEPTH);
        for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[15];

    initial begin
        vecs[0]  = '{1'b1, 30'd5,     32'hAABBCCDD, 4'b1111, 32'h0};
        vecs[1]  = '{1'b1, 30'd5,     32'h11223344, 4'b0101, 32'h0};
        vecs[2]  = '{1'b0, 30'd5,     32'h0,        4'b0000, 32'hAA22CC44};
        vecs[3]  = '{1'b1, 30'd3,     32'hDEADBEEF, 4'b1111, 32'h0};
        vecs[4]  = '{1'b0, 30'd3,     32'h0,        4'b0000, 32'hDEADBEEF};
        vecs[5]  = '{1'b1, 30'h10,    32'h5A5A5A5A, 4'b1111, 32'h0};
        vecs[6]  = '{1'b0, 30'd0,     32'h0,        4'b0000, 32'h5A5A5A5A};
        vecs[7]  = '{1'b1, 30'd7,     32'hFFFFFFFF, 4'b0000, 32'h0};
        vecs[8]  = '{1'b0, 30'd7,     32'h0,        4'b0000, 32'h00000000};
        vecs[9]  = '{1'b0, 30'h3F5,   32'h0,        4'b0000, 32'hAA22CC44};
        vecs[10] = '{1'b1, 30'd9,     32'h12345678, 4'b1000, 32'h0};
        vecs[11] = '{1'b0, 30'd9,     32'h0,        4'b0000, 32'h12000000};
        vecs[12] = '{1'b0, 30'd5,     32'h0,        4'b0000, 32'hAA22CC44};
        vecs[13] = '{1'b1, 30'd5,     32'h0,        4'b1111, 32'h0};
        vecs[14] = '{1'b0, 30'd5,     32'h0,        4'b0000, 32'h00000000};

        reset     = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        addr      = '0;
        wdata     = '0;
        wstrb     = '0;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        @(negedge clk);
        chk("reset_ready_l1", {31'd0, rdy1}, 32'd0);
        chk("reset_ready_l2", {31'd0, rdy2}, 32'd0);
        @(posedge clk);
        #1;

        reset_and_clear("clear_len_initial");
        for (int i = 0; i < DEPTH; i++) issue(1'b0, 30'(i), '0, '0, 1'b1, 32'h0);

        foreach (vecs[i])
            issue(vecs[i].we, vecs[i].a, vecs[i].d, vecs[i].s, 1'b1, vecs[i].exp);
        idle(3);

        for (int i = 0; i < 8; i++) issue(1'b1, 30'(i), 32'h100 + i, 4'hF, 1'b0, '0);
        for (int i = 0; i < 8; i++) issue(1'b0, 30'(i), '0, '0, 1'b1, 32'h100 + i);
        idle(3);

        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(3) == 0) idle(1);
            else issue(1'($urandom_range(1)), 30'($urandom()), $urandom(),
                       4'($urandom_range(15)), 1'b0, '0);
        end
        idle(3);

        // Read accepted, reset on the very next cycle: the LATENCY=2 response is lost.
        issue(1'b0, 30'd2, '0, '0, 1'b0, '0);
        reset_and_clear("clear_len_after_drop");
        chk("drop_rdata_l2", rd2, 32'h0);
        chk("drop_rdata_l1", rd1, 32'h0);

        for (int i = 0; i < DEPTH; i++) issue(1'b1, 30'(i), 32'hC0DE0000 + i, 4'hF, 1'b0, '0);
        reset     = 1'b1;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        reset_and_clear("clear_len_restart");
        for (int i = 0; i < DEPTH; i++) issue(1'b0, 30'(i), '0, '0, 1'b1, 32'h0);
        idle(4);

        chk("drain_l1", q1.size(), 0);
        chk("drain_l2", q2.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
